// File: rtl/fft_bin_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_bin_streamer: buffers one FFT frame, replays it as a magnitude session |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module fft_bin_streamer #(
    parameter int DATA_W = 25,
    parameter int N_BINS = 8192,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sink_valid,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [DATA_W-1:0] sink_real,
    input  logic [DATA_W-1:0] sink_imag,
    output logic              sink_ready,
    output logic              sm_ready,
    output logic              sm_enable,
    output logic              sm_done,
    output logic [DATA_W-1:0] source_real,
    output logic [DATA_W-1:0] source_imag,
    output logic [ADDR_W-1:0] bin_index,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   wr_cnt_q;
    logic [ADDR_W-1:0]   rd_cnt_q;
    logic                rd_busy_q;
    logic                rd_vld_q;
    logic [ADDR_W-1:0]   rd_idx_q;
    logic                sink_ready_q;
    logic                sm_ready_q;
    logic                sm_enable_q;
    logic                sm_done_q;
    logic                frame_err_q;
    logic [DATA_W-1:0]   src_real_q;
    logic [DATA_W-1:0]   src_imag_q;
    logic [ADDR_W-1:0]   bin_index_q;
    logic [2*DATA_W-1:0] ram_rd_q;
    logic [2*DATA_W-1:0] mem [0:N_BINS-1];

    logic              beat_acc_d;
    logic              wr_en_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] wr_addr_d;

    // A nonzero write count doubles as "a frame is open"; beats before sop are dropped.
    always_comb begin
        beat_acc_d = (state_q == S_FILL) && sink_valid && sink_ready_q;
        wr_addr_d  = sink_sop ? '0 : wr_cnt_q;
        wr_en_d    = beat_acc_d && (sink_sop || (wr_cnt_q != '0));
        rd_en_d    = (state_q == S_STREAM) && rd_busy_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wr_addr_d] <= {sink_real, sink_imag};
        end
        if (rd_en_d) begin
            ram_rd_q <= mem[rd_cnt_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_busy_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_idx_q     <= '0;
            sink_ready_q <= 1'b0;
            sm_ready_q   <= 1'b0;
            sm_enable_q  <= 1'b0;
            sm_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            src_real_q   <= '0;
            src_imag_q   <= '0;
            bin_index_q  <= '0;
        end else begin
            frame_err_q <= 1'b0;
            sm_done_q   <= 1'b0;
            rd_vld_q    <= rd_en_d;
            rd_idx_q    <= rd_cnt_q;
            case (state_q)
                S_FILL: begin
                    sink_ready_q <= 1'b1;
                    sm_ready_q   <= 1'b0;
                    sm_enable_q  <= 1'b0;
                    if (wr_en_d) begin
                        if (sink_sop && (wr_cnt_q != '0)) begin
                            frame_err_q <= 1'b1;
                        end
                        if (wr_addr_d == LAST_ADDR) begin
                            // Full frame is kept even without eop on the last beat.
                            if (!sink_eop) begin
                                frame_err_q <= 1'b1;
                            end
                            wr_cnt_q     <= '0;
                            sink_ready_q <= 1'b0;
                            rd_busy_q    <= 1'b1;
                            rd_cnt_q     <= '0;
                            state_q      <= S_STREAM;
                        end else if (sink_eop) begin
                            frame_err_q <= 1'b1;
                            wr_cnt_q    <= '0;
                        end else begin
                            wr_cnt_q <= wr_addr_d + ONE;
                        end
                    end
                end
                S_STREAM: begin
                    if (rd_en_d) begin
                        rd_cnt_q <= rd_cnt_q + ONE;
                        if (rd_cnt_q == LAST_ADDR) begin
                            rd_busy_q <= 1'b0;
                        end
                    end
                    sm_enable_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        src_real_q  <= ram_rd_q[2*DATA_W-1:DATA_W];
                        src_imag_q  <= ram_rd_q[DATA_W-1:0];
                        bin_index_q <= rd_idx_q;
                        sm_ready_q  <= 1'b1;
                        if (rd_idx_q == LAST_ADDR) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // sm_ready stays high through the sm_done cycle.
                    sm_enable_q <= 1'b0;
                    sm_done_q   <= 1'b1;
                    wr_cnt_q    <= '0;
                    rd_cnt_q    <= '0;
                    state_q     <= S_FILL;
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

    assign sink_ready  = sink_ready_q;
    assign sm_ready    = sm_ready_q;
    assign sm_enable   = sm_enable_q;
    assign sm_done     = sm_done_q;
    assign frame_err   = frame_err_q;
    assign source_real = src_real_q;
    assign source_imag = src_imag_q;
    assign bin_index   = bin_index_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_streamer.sv
`default_nettype none
// Bench for fft_bin_streamer: small (8-bin) instance with a queue-level frame model,
// plus a full-size instance replaying a random 8192-bin frame.
module tb_fft_bin_streamer;

    localparam int DW = 25;
    localparam int SN = 8;
    localparam int SA = 3;
    localparam int BN = 8192;
    localparam int BA = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic          a_valid, a_sop, a_eop;
    logic [DW-1:0] a_real, a_imag;
    logic          a_sink_ready, a_sm_ready, a_sm_enable, a_sm_done, a_frame_err;
    logic [DW-1:0] a_src_real, a_src_imag;
    logic [SA-1:0] a_bin_index;

    logic          b_valid, b_sop, b_eop;
    logic [DW-1:0] b_real, b_imag;
    logic          b_sink_ready, b_sm_ready, b_sm_enable, b_sm_done, b_frame_err;
    logic [DW-1:0] b_src_real, b_src_imag;
    logic [BA-1:0] b_bin_index;

    fft_bin_streamer #(.DATA_W(DW), .N_BINS(SN), .ADDR_W(SA)) u_small (
        .clk(clk), .reset_n(reset_n),
        .sink_valid(a_valid), .sink_sop(a_sop), .sink_eop(a_eop),
        .sink_real(a_real), .sink_imag(a_imag), .sink_ready(a_sink_ready),
        .sm_ready(a_sm_ready), .sm_enable(a_sm_enable), .sm_done(a_sm_done),
        .source_real(a_src_real), .source_imag(a_src_imag),
        .bin_index(a_bin_index), .frame_err(a_frame_err)
    );

    fft_bin_streamer #(.DATA_W(DW), .N_BINS(BN), .ADDR_W(BA)) u_big (
        .clk(clk), .reset_n(reset_n),
        .sink_valid(b_valid), .sink_sop(b_sop), .sink_eop(b_eop),
        .sink_real(b_real), .sink_imag(b_imag), .sink_ready(b_sink_ready),
        .sm_ready(b_sm_ready), .sm_enable(b_sm_enable), .sm_done(b_sm_done),
        .source_real(b_src_real), .source_imag(b_src_imag),
        .bin_index(b_bin_index), .frame_err(b_frame_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Posedges seen since reset release (saturating).
    int pe;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pe <= 0;
        else if (pe < 3) pe <= pe + 1;
    end

    // Frame model for the small instance.
    bit            strm, err_pend, err_next, take;
    int            k, cur_n;
    logic [DW-1:0] cur_re [SN];
    logic [DW-1:0] cur_im [SN];
    logic [DW-1:0] fr_re  [SN];
    logic [DW-1:0] fr_im  [SN];
    int            a_err_seen = 0, a_done_cnt = 0;
    bit            en_e, rdy_e, done_e, sr_e;

    logic [DW-1:0] b_re [BN];
    logic [DW-1:0] b_im [BN];
    int            b_cnt = 0, b_done_cnt = 0;
    bit            b_prev_en = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("a_reset_outputs", {a_sink_ready, a_sm_ready, a_sm_enable, a_sm_done, a_frame_err,
                                    a_src_real, a_src_imag, a_bin_index}, '0);
            chk("b_reset_flags", {b_sink_ready, b_sm_ready, b_sm_enable, b_sm_done, b_frame_err}, '0);
            chk("b_reset_data", {b_src_real, b_src_imag, b_bin_index}, '0);
            strm = 0; k = 0; cur_n = 0; err_pend = 0;
            b_cnt = 0; b_prev_en = 0;
        end else begin
            if (strm) begin
                k++;
                en_e   = (k >= 2) && (k <= SN + 1);
                rdy_e  = (k >= 2) && (k <= SN + 2);
                done_e = (k == SN + 2);
                sr_e   = (k >= SN + 3);
                if (k >= SN + 3) strm = 0;
            end else begin
                en_e = 0; rdy_e = 0; done_e = 0;
                sr_e = (pe >= 1);
            end
            chk("a_sm_enable", a_sm_enable, en_e);
            chk("a_sm_ready", a_sm_ready, rdy_e);
            chk("a_sm_done", a_sm_done, done_e);
            chk("a_sink_ready", a_sink_ready, sr_e);
            if (en_e && a_sm_enable) begin
                chk("a_bin_index", a_bin_index, k - 2);
                chk("a_bin_data", {a_src_real, a_src_imag}, {fr_re[k-2], fr_im[k-2]});
            end
            chk("a_frame_err", a_frame_err, err_pend);
            if (a_frame_err) a_err_seen++;
            if (a_sm_done) a_done_cnt++;

            err_next = 0;
            if (a_valid && a_sink_ready) begin
                take = a_sop || (cur_n != 0);
                if (a_sop) begin
                    if (cur_n != 0) err_next = 1;
                    cur_n = 0;
                end
                if (take) begin
                    cur_re[cur_n] = a_real;
                    cur_im[cur_n] = a_imag;
                    cur_n++;
                    if (cur_n == SN) begin
                        for (int i = 0; i < SN; i++) begin
                            fr_re[i] = cur_re[i];
                            fr_im[i] = cur_im[i];
                        end
                        strm = 1; k = -1;
                        if (!a_eop) err_next = 1;
                        cur_n = 0;
                    end else if (a_eop) begin
                        err_next = 1;
                        cur_n = 0;
                    end
                end
            end
            err_pend = err_next;

            if (b_sm_enable) begin
                if (b_cnt < BN) begin
                    chk("b_bin_index", b_bin_index, b_cnt);
                    chk("b_bin_data", {b_src_real, b_src_imag}, {b_re[b_cnt], b_im[b_cnt]});
                end else begin
                    chk("b_extra_enable", b_cnt, BN - 1);
                end
                b_cnt++;
            end else if (b_prev_en && b_cnt < BN) begin
                chk("b_contiguous", b_cnt, BN);
            end
            if (b_sm_done) begin
                b_done_cnt++;
                chk("b_done_timing", {b_prev_en, b_cnt == BN}, 2'b11);
            end
            chk("b_frame_err", b_frame_err, 1'b0);
            b_prev_en = b_sm_enable;
        end
    end

    task automatic send_a(input bit sop, input bit eop, input int re, input int im);
        int w;
        a_valid = 1; a_sop = sop; a_eop = eop;
        a_real = re[DW-1:0]; a_imag = im[DW-1:0];
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!a_sink_ready && w < 100);
        if (!a_sink_ready) chk("a_send_timeout", a_sink_ready, 1'b1);
        @(posedge clk); #1;
        a_valid = 0; a_sop = 0; a_eop = 0;
    endtask

    task automatic send_frame_a(input int base);
        for (int i = 0; i < SN; i++) send_a(i == 0, i == SN - 1, base + i, -(base + i));
    endtask

    task automatic wait_done_a();
        int w;
        w = 0;
        while (!a_sm_done && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!a_sm_done) chk("a_done_timeout", a_sm_done, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_b(input bit sop, input bit eop, input logic [DW-1:0] re, input logic [DW-1:0] im);
        int w;
        b_valid = 1; b_sop = sop; b_eop = eop; b_real = re; b_imag = im;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!b_sink_ready && w < 100);
        if (!b_sink_ready) chk("b_send_timeout", b_sink_ready, 1'b1);
        @(posedge clk); #1;
        b_valid = 0; b_sop = 0; b_eop = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e0, d0;
        a_valid = 0; a_sop = 0; a_eop = 0; a_real = '0; a_imag = '0;
        b_valid = 0; b_sop = 0; b_eop = 0; b_real = '0; b_imag = '0;
        reset_n = 1;
        #1 reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Basic frame: real=k, imag=-k.
        send_frame_a(0);
        n = 0;
        while (!a_sm_enable && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_first_enable_latency", n, 2);
        chk("a_first_bin_index", a_bin_index, 3'd0);
        chk("a_first_bin_data", {a_src_real, a_src_imag}, 50'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_bin3_index", a_bin_index, 3'd3);
        chk("a_bin3_real", a_src_real, 25'd3);
        chk("a_bin3_imag", a_src_imag, 25'h1FFFFFD);
        wait_done_a();
        chk("a_done_count_t1", a_done_cnt, 1);

        // Stray beat, short frame (eop on beat 4), then a full frame.
        e0 = a_err_seen;
        send_a(0, 0, 99, -99);
        for (int i = 0; i < 5; i++) send_a(i == 0, i == 4, 10 + i, -(10 + i));
        repeat (3) @(posedge clk);
        #1;
        chk("a_short_frame_err_pulses", a_err_seen - e0, 1);
        chk("a_short_frame_no_done", a_done_cnt, 1);
        send_frame_a(20);
        wait_done_a();
        chk("a_done_count_t2", a_done_cnt, 2);

        // Back-pressure: valid held across two frames.
        send_frame_a(30);
        send_frame_a(40);
        wait_done_a();
        chk("a_done_count_t3", a_done_cnt, 4);

        // Mid-frame sop at beat 3 restarts the frame.
        e0 = a_err_seen;
        for (int i = 0; i < 3; i++) send_a(i == 0, 0, 50 + i, -(50 + i));
        send_frame_a(60);
        wait_done_a();
        chk("a_restart_err_pulses", a_err_seen - e0, 1);
        chk("a_done_count_t4", a_done_cnt, 5);

        // Reset during stream at bin 4.
        d0 = a_done_cnt;
        send_frame_a(70);
        n = 0;
        while (!(a_sm_enable && a_bin_index == 3'd4) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_reached_bin4", {a_sm_enable, a_bin_index}, 4'b1100);
        #2 reset_n = 0;
        #1;
        chk("a_async_reset_outputs", {a_sink_ready, a_sm_ready, a_sm_enable, a_sm_done,
                                      a_frame_err, a_src_real, a_src_imag, a_bin_index}, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("a_no_done_after_reset", a_done_cnt, d0);
        send_frame_a(80);
        wait_done_a();
        chk("a_done_count_t5", a_done_cnt, d0 + 1);

        // Full-size frame with random signed data.
        for (int i = 0; i < BN; i++) begin
            b_re[i] = 25'($urandom);
            b_im[i] = 25'($urandom);
        end
        for (int i = 0; i < BN; i++) send_b(i == 0, i == BN - 1, b_re[i], b_im[i]);
        n = 0;
        while (!b_sm_done && n < 9000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b_done_count", b_done_cnt, 1);
        chk("b_bins_streamed", b_cnt, BN);
        chk("b_sink_ready_back", b_sink_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
